// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the N-phase intersection controller:
//   - controller state encoding (ALLRED / GREEN / YELLOW / FLASH)
//   - per-lamp {R,Y,G} codes driven onto each phase's 3-bit light field
//   - legal range for the number of phases and a helper to check it
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } light_state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam int MIN_PHASES = 2;
    localparam int MAX_PHASES = 8;

    function automatic bit phase_count_legal(input int n);
        return (n >= MIN_PHASES) && (n <= MAX_PHASES);
    endfunction

endpackage

// File: rtl/traffic_phase_select.sv
// ---------------------------------------------------------------------------
// traffic_phase_select
// Combinational rotating-priority finder. Starting just after last_phase and
// wrapping around (last_phase itself is considered last), returns the first
// phase whose eligible bit is set.
// Ports:
//   eligible   in  NUM_PHASES  phases that may be served next
//   last_phase in  PW          phase served most recently
//   next_phase out PW          selected phase (last_phase when none found)
//   found      out 1           at least one eligible phase exists
// ---------------------------------------------------------------------------
module traffic_phase_select
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int PW         = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] eligible,
    input  logic [PW-1:0]         last_phase,
    output logic [PW-1:0]         next_phase,
    output logic                  found
);

    int scan_idx;

    // Walk the ring once, beginning at the phase after last_phase, and keep
    // the first hit only.
    always_comb begin
        next_phase = last_phase;
        found      = 1'b0;
        scan_idx   = 0;
        for (int step = 1; step <= NUM_PHASES; step++) begin
            scan_idx = int'(last_phase) + step;
            if (scan_idx >= NUM_PHASES) begin
                scan_idx = scan_idx - NUM_PHASES;
            end
            if (!found && eligible[scan_idx]) begin
                found      = 1'b1;
                next_phase = scan_idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// traffic_phase_controller
// N-phase intersection controller. Serves phases round-robin with the cycle
// GREEN -> YELLOW -> ALL-RED, skipping phases with no green time unless a
// pedestrian request is latched for them. Supports a freeze input and a
// flashing fail-safe mode. All outputs are registered and change on the same
// edge as the controller state.
// Ports:
//   clk          in   1              rising-edge clock
//   reset_n      in   1              asynchronous active-low reset
//   enable       in   1              1 = run, 0 = freeze state/timer/blink
//   flash_mode   in   1              request flashing fail-safe mode
//   green_time   in   NUM_PHASES*TW  per-phase green duration, phase p at [p*TW +: TW]
//   yellow_time  in   TW             yellow duration
//   allred_time  in   TW             all-red clearance duration
//   ped_req      in   NUM_PHASES     pedestrian requests (sticky once seen)
//   light        out  NUM_PHASES*3   per-phase {R,Y,G} lamp code
//   active_phase out  PW             phase in GREEN/YELLOW, last served otherwise
//   ped_walk     out  NUM_PHASES     walk indication for the phase in GREEN
//   phase_done   out  1              pulse on the YELLOW -> ALL-RED edge
// ---------------------------------------------------------------------------
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int TW         = 8,
    parameter int MIN_GREEN  = 8,
    parameter int RESET_HOLD = 4,
    parameter int FLASH_HALF = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          flash_mode,
    input  logic [NUM_PHASES*TW-1:0]      green_time,
    input  logic [TW-1:0]                 yellow_time,
    input  logic [TW-1:0]                 allred_time,
    input  logic [NUM_PHASES-1:0]         ped_req,
    output logic [NUM_PHASES*3-1:0]       light,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [NUM_PHASES-1:0]         ped_walk,
    output logic                          phase_done
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int BW = $clog2(FLASH_HALF + 1);

    if (!phase_count_legal(NUM_PHASES)) begin : g_bad_phase_count
        $error("traffic_phase_controller: NUM_PHASES must be in 2..8");
    end

    light_state_t            state;
    logic [TW-1:0]           timer;
    logic [NUM_PHASES-1:0]   ped_latch;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_on;

    logic [NUM_PHASES-1:0]   eligible;
    logic [PW-1:0]           sel_phase;
    logic                    sel_found;
    logic [TW-1:0]           sel_green;
    logic [TW-1:0]           green_load;
    logic                    serve_now;
    logic [NUM_PHASES-1:0]   serve_grant;

    // A state lasting D cycles holds max(D,1) cycles: the timer is loaded
    // with max(D,1)-1 and the state is left when it reaches zero.
    function automatic logic [TW-1:0] load_value(input logic [TW-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // Lamp pattern for a given state; RED everywhere except the served phase,
    // or the blink pattern while flashing.
    function automatic logic [NUM_PHASES*3-1:0] lamp_pattern(
        input light_state_t st,
        input logic [PW-1:0] p,
        input logic          lit
    );
        logic [NUM_PHASES*3-1:0] v;
        for (int i = 0; i < NUM_PHASES; i++) begin
            v[i*3 +: 3] = LAMP_RED;
            if (st == ST_FLASH) begin
                v[i*3 +: 3] = !lit ? LAMP_OFF : ((i == 0) ? LAMP_YELLOW : LAMP_RED);
            end else if (i == int'(p)) begin
                if (st == ST_GREEN) begin
                    v[i*3 +: 3] = LAMP_GREEN;
                end else if (st == ST_YELLOW) begin
                    v[i*3 +: 3] = LAMP_YELLOW;
                end
            end
        end
        return v;
    endfunction

    // A phase may be served if it has green time of its own or a pedestrian
    // is waiting on it. Only the registered latch counts, so a request
    // arriving on the decision edge waits for the next round.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            eligible[i] = (green_time[i*TW +: TW] != '0) || ped_latch[i];
        end
    end

    traffic_phase_select #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_select (
        .eligible   (eligible),
        .last_phase (active_phase),
        .next_phase (sel_phase),
        .found      (sel_found)
    );

    // Green for the chosen phase; a ped-only phase (zero green) gets MIN_GREEN.
    assign sel_green  = green_time[sel_phase*TW +: TW];
    assign green_load = (sel_green == '0) ? TW'(MIN_GREEN - 1) : sel_green - 1'b1;

    // The edge on which ALL-RED hands over to a new GREEN; also the edge that
    // consumes that phase's pedestrian latch.
    assign serve_now   = (state == ST_ALLRED) && enable && (timer == '0)
                         && !flash_mode && sel_found;
    assign serve_grant = serve_now ? (NUM_PHASES'(1) << sel_phase) : '0;

    // Pedestrian latches keep capturing even while frozen. A new request on
    // the same edge the latch is consumed wins, so it is served next time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_latch <= '0;
        end else begin
            ped_latch <= (ped_latch & ~serve_grant) | ped_req;
        end
    end

    // Main sequencer. When frozen every register, including the outputs and
    // the phase_done pulse, simply holds its value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ALLRED;
            timer        <= TW'(RESET_HOLD - 1);
            active_phase <= PW'(NUM_PHASES - 1);
            light        <= {NUM_PHASES{LAMP_RED}};
            ped_walk     <= '0;
            phase_done   <= 1'b0;
            blink_cnt    <= '0;
            blink_on     <= 1'b1;
        end else if (enable) begin
            phase_done <= 1'b0;
            case (state)
                ST_ALLRED: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (flash_mode) begin
                        state     <= ST_FLASH;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        light     <= lamp_pattern(ST_FLASH, active_phase, 1'b1);
                        ped_walk  <= '0;
                    end else if (sel_found) begin
                        state        <= ST_GREEN;
                        active_phase <= sel_phase;
                        timer        <= green_load;
                        light        <= lamp_pattern(ST_GREEN, sel_phase, 1'b1);
                        ped_walk     <= serve_grant;
                    end else begin
                        timer <= load_value(allred_time);
                    end
                end
                ST_GREEN: begin
                    // A flash request cuts green short but still goes through yellow.
                    if ((timer == '0) || flash_mode) begin
                        state    <= ST_YELLOW;
                        timer    <= load_value(yellow_time);
                        light    <= lamp_pattern(ST_YELLOW, active_phase, 1'b1);
                        ped_walk <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (timer == '0) begin
                        state      <= ST_ALLRED;
                        timer      <= load_value(allred_time);
                        light      <= {NUM_PHASES{LAMP_RED}};
                        phase_done <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_FLASH: begin
                    // Leaving flash restarts the rotation so phase 0 comes first.
                    if (!flash_mode) begin
                        state        <= ST_ALLRED;
                        timer        <= load_value(allred_time);
                        active_phase <= PW'(NUM_PHASES - 1);
                        light        <= {NUM_PHASES{LAMP_RED}};
                    end else if (blink_cnt == BW'(FLASH_HALF - 1)) begin
                        blink_cnt <= '0;
                        blink_on  <= !blink_on;
                        light     <= lamp_pattern(ST_FLASH, active_phase, !blink_on);
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_ALLRED;
                    timer <= load_value(allred_time);
                    light <= {NUM_PHASES{LAMP_RED}};
                end
            endcase
        end
    end

endmodule
